alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an ALU class and funct fields into an ALU operation
// and buffers up to two operations (output register plus skid entry) in FIFO order.
module alu_issue_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_alu_op,
    input  logic [2:0]   in_funct3,
    input  logic         in_funct7b5,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [4:0]   in_rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_op,
    output logic         out_cin,
    output logic [N-1:0] out_a,
    output logic [N-1:0] out_b,
    output logic [4:0]   out_rd,
    output logic         illegal_op,
    output logic [15:0]  issue_count
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    logic [3:0]   w_op;
    logic         w_cin;
    logic         w_legal;
    logic         w_acc;
    logic         w_push;
    logic         w_drain;
    logic         w_next_full;

    logic         r_out_valid;
    logic [3:0]   r_out_op;
    logic [N-1:0] r_out_a;
    logic [N-1:0] r_out_b;
    logic [4:0]   r_out_rd;
    logic         r_skid_valid;
    logic [3:0]   r_skid_op;
    logic [N-1:0] r_skid_a;
    logic [N-1:0] r_skid_b;
    logic [4:0]   r_skid_rd;
    logic         r_in_ready;
    logic         r_illegal;
    logic [15:0]  r_issue_count;

    always_comb begin
        w_op    = OP_ADD;
        w_legal = 1'b1;
        case (in_alu_op)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (!in_funct7b5) begin
                    case (in_funct3)
                        3'b000:  w_op = OP_ADD;
                        3'b111:  w_op = OP_AND;
                        3'b110:  w_op = OP_OR;
                        3'b010:  w_op = OP_SLT;
                        default: w_legal = 1'b0;
                    endcase
                end else begin
                    case (in_funct3)
                        3'b000:  w_op = OP_SUB;
                        3'b110:  w_op = OP_NOR;
                        3'b111:  w_op = OP_NAND;
                        default: w_legal = 1'b0;
                    endcase
                end
            end
            default: begin
                case (in_funct3)
                    3'b000:  w_op = OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    3'b010:  w_op = OP_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
        endcase
    end

    // Carry-in is a pure function of the operation, so it is not stored.
    always_comb begin
        w_cin = (r_out_op == OP_SUB) || (r_out_op == OP_SLT) || (r_out_op == OP_NAND);
    end

    assign w_acc   = in_valid && r_in_ready;
    assign w_push  = w_acc && w_legal;
    assign w_drain = r_out_valid && out_ready;

    // The skid entry is only ever filled while the output register is held.
    assign w_next_full = (r_skid_valid && !w_drain) ||
                         (r_out_valid && !r_skid_valid && !w_drain && w_push);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_op      <= '0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_out_rd      <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_op     <= '0;
            r_skid_a      <= '0;
            r_skid_b      <= '0;
            r_skid_rd     <= '0;
            r_in_ready    <= 1'b1;
            r_illegal     <= 1'b0;
            r_issue_count <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_illegal    <= 1'b0;
        end else begin
            r_illegal  <= w_acc && !w_legal;
            r_in_ready <= !w_next_full;
            if (w_drain) begin
                r_issue_count <= r_issue_count + 16'd1;
            end
            if (r_skid_valid) begin
                if (w_drain) begin
                    r_out_op     <= r_skid_op;
                    r_out_a      <= r_skid_a;
                    r_out_b      <= r_skid_b;
                    r_out_rd     <= r_skid_rd;
                    r_skid_valid <= 1'b0;
                end
            end else if (r_out_valid && !w_drain) begin
                if (w_push) begin
                    r_skid_op    <= w_op;
                    r_skid_a     <= in_a;
                    r_skid_b     <= in_b;
                    r_skid_rd    <= in_rd;
                    r_skid_valid <= 1'b1;
                end
            end else begin
                r_out_valid <= w_push;
                if (w_push) begin
                    r_out_op <= w_op;
                    r_out_a  <= in_a;
                    r_out_b  <= in_b;
                    r_out_rd <= in_rd;
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_op      = r_out_valid ? r_out_op : 4'b0000;
    assign out_cin     = r_out_valid && w_cin;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_rd      = r_out_rd;
    assign illegal_op  = r_illegal;
    assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode table, skid buffering,
// illegal-op pulses, flush, reset and issue counter wraparound.
module tb_alu_issue_stage;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_alu_op;
    logic [2:0]   in_funct3;
    logic         in_funct7b5;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [4:0]   in_rd;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_op;
    logic         out_cin;
    logic [N-1:0] out_a;
    logic [N-1:0] out_b;
    logic [4:0]   out_rd;
    logic         illegal_op;
    logic [15:0]  issue_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    alu_issue_stage #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_op   (in_alu_op),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_cin     (out_cin),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .illegal_op  (illegal_op),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [N-1:0] a, input logic [N-1:0] b, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_alu_op   = op;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_a        = a;
        in_b        = b;
        in_rd       = rd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({pfx, "_in_ready"},  64'(in_ready),  64'd1);
        chk({pfx, "_out_op"},    64'(out_op),    64'd0);
        chk({pfx, "_out_cin"},   64'(out_cin),   64'd0);
        chk({pfx, "_out_a"},     out_a,          64'd0);
        chk({pfx, "_out_b"},     out_b,          64'd0);
        chk({pfx, "_out_rd"},    64'(out_rd),    64'd0);
        chk({pfx, "_illegal"},   64'(illegal_op), 64'd0);
        chk({pfx, "_count"},     64'(issue_count), 64'd0);
    endtask

    // alu_op, funct3, funct7b5, expected op, expected cin, legal
    typedef struct {
        logic [1:0] alu_op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] op;
        logic       cin;
        logic       legal;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{2'b00, 3'b101, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[1]  = '{2'b01, 3'b011, 1'b0, 4'b0110, 1'b1, 1'b1};
        vecs[2]  = '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0, 1'b1};
        vecs[3]  = '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[4]  = '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 3'b010, 1'b0, 4'b0111, 1'b1, 1'b1};
        vecs[6]  = '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b1, 1'b1};
        vecs[7]  = '{2'b10, 3'b110, 1'b1, 4'b1100, 1'b0, 1'b1};
        vecs[8]  = '{2'b10, 3'b111, 1'b1, 4'b1101, 1'b1, 1'b1};
        vecs[9]  = '{2'b10, 3'b001, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 3'b010, 1'b1, 4'b0000, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[12] = '{2'b11, 3'b111, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 3'b110, 1'b1, 4'b0001, 1'b0, 1'b1};
        vecs[14] = '{2'b11, 3'b010, 1'b0, 4'b0111, 1'b1, 1'b1};
        vecs[15] = '{2'b11, 3'b101, 1'b0, 4'b0000, 1'b0, 1'b0};

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu_op = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_a = '0; in_b = '0; in_rd = '0;
        tick();
        do_reset();
        check_reset_state("rst");

        // SUB with operands passed through unmodified, one-cycle latency
        out_ready = 1'b1;
        drive(2'b10, 3'b000, 1'b1, 64'd5, 64'd7, 5'd3);
        tick();
        in_valid = 1'b0;
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_op",    64'(out_op),    64'b0110);
        chk("sub_cin",   64'(out_cin),   64'd1);
        chk("sub_a",     out_a,          64'd5);
        chk("sub_b",     out_b,          64'd7);
        chk("sub_rd",    64'(out_rd),    64'd3);
        tick();
        exp_cnt++;
        chk("sub_drained", 64'(out_valid), 64'd0);
        chk("idle_op",     64'(out_op),    64'd0);
        chk("sub_count",   64'(issue_count), 64'(exp_cnt));

        // Full decode table including illegal combinations
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].alu_op, vecs[i].f3, vecs[i].f7, 64'(i), 64'(i + 100), 5'(i));
            tick();
            in_valid = 1'b0;
            chk($sformatf("dec%0d_valid", i), 64'(out_valid), 64'(vecs[i].legal));
            chk($sformatf("dec%0d_illegal", i), 64'(illegal_op), 64'(!vecs[i].legal));
            chk($sformatf("dec%0d_op", i), 64'(out_op), 64'(vecs[i].op));
            chk($sformatf("dec%0d_cin", i), 64'(out_cin), 64'(vecs[i].cin));
            tick();
            if (vecs[i].legal) exp_cnt++;
            chk($sformatf("dec%0d_pulse_end", i), 64'(illegal_op), 64'd0);
        end
        chk("dec_count", 64'(issue_count), 64'(exp_cnt));

        // Back-pressure: two entries fill, then FIFO drain in order
        out_ready = 1'b0;
        drive(2'b11, 3'b000, 1'b0, 64'd100, 64'd0, 5'd10);
        tick();
        chk("bp1_ready", 64'(in_ready), 64'd1);
        chk("bp1_a",     out_a,         64'd100);
        drive(2'b11, 3'b000, 1'b0, 64'd101, 64'd0, 5'd11);
        tick();
        chk("bp2_ready", 64'(in_ready), 64'd0);
        chk("bp2_a",     out_a,         64'd100);
        drive(2'b11, 3'b000, 1'b0, 64'd102, 64'd0, 5'd12);
        tick();
        chk("bp3_ready", 64'(in_ready), 64'd0);
        chk("bp3_a",     out_a,         64'd100);
        out_ready = 1'b1;
        tick();
        chk("bp4_a",     out_a,         64'd101);
        chk("bp4_rd",    64'(out_rd),   64'd11);
        chk("bp4_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp5_a",     out_a,         64'd102);
        chk("bp5_ready", 64'(in_ready), 64'd1);
        drive(2'b11, 3'b000, 1'b0, 64'd103, 64'd0, 5'd13);
        tick();
        in_valid = 1'b0;
        chk("bp6_a",     out_a,         64'd103);
        chk("bp6_valid", 64'(out_valid), 64'd1);
        tick();
        exp_cnt += 4;
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_count",   64'(issue_count), 64'(exp_cnt));

        // Flush with two entries held, same-edge drain not counted
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 64'd1, 64'd1, 5'd1);
        tick();
        tick();
        chk("fl_full", 64'(in_ready), 64'd0);
        drive(2'b10, 3'b001, 1'b0, 64'd9, 64'd9, 5'd9);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid",   64'(out_valid),   64'd0);
        chk("fl_ready",   64'(in_ready),    64'd1);
        chk("fl_illegal", 64'(illegal_op),  64'd0);
        chk("fl_op",      64'(out_op),      64'd0);
        chk("fl_count",   64'(issue_count), 64'(exp_cnt));

        // Flush overrides same-edge acceptance of an illegal op
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 64'd2, 64'd2, 5'd2);
        tick();
        drive(2'b11, 3'b001, 1'b0, 64'd9, 64'd9, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_valid",   64'(out_valid),  64'd0);
        chk("fl2_illegal", 64'(illegal_op), 64'd0);
        tick();
        chk("fl2_illegal_late", 64'(illegal_op), 64'd0);
        chk("fl2_valid_late",   64'(out_valid),  64'd0);

        // Reset with two entries held and an illegal op in flight
        drive(2'b00, 3'b000, 1'b0, 64'd3, 64'd4, 5'd5);
        tick();
        tick();
        drive(2'b10, 3'b011, 1'b0, 64'd9, 64'd9, 5'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        exp_cnt = 0;
        check_reset_state("rst2");
        out_ready = 1'b1;
        drive(2'b01, 3'b000, 1'b0, 64'd42, 64'd43, 5'd7);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_a",     out_a,          64'd42);
        chk("post_rst_op",    64'(out_op),    64'b0110);

        // Counter wraparound: 65535 handshakes then one more
        do_reset();
        out_ready = 1'b1;
        drive(2'b00, 3'b000, 1'b0, 64'd0, 64'd0, 5'd0);
        for (int i = 0; i < 65535; i++) tick();
        in_valid = 1'b0;
        tick();
        chk("cnt_ffff", 64'(issue_count), 64'hFFFF);
        drive(2'b00, 3'b000, 1'b0, 64'd0, 64'd0, 5'd0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("cnt_wrap",       64'(issue_count), 64'h0000);
        chk("cnt_wrap_valid", 64'(out_valid),   64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
